// File: rtl/hdr_route_stage.sv
// hdr_route_stage: next-hop route compute for one mesh router.
// Reads the target row/column and routing mode from each header, picks the
// output port, rewrites the next-jump byte with the neighbour's coordinates,
// and forwards legal packets through a 2-entry in-order output FIFO.
// Packets that target a coordinate outside the mesh are consumed and counted
// as errors.

module hdr_route_stage #(
  parameter int PCK_SZ  = 40,
  parameter int ROW     = 2,
  parameter int COLUMN  = 2,
  parameter int ROWS    = 4,
  parameter int COLUMNS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [PCK_SZ-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [PCK_SZ-1:0] out_data,
  output logic [2:0]        out_port,
  input  logic              out_ready,
  output logic [15:0]       pkt_cnt,
  output logic [7:0]        err_cnt
);

  // Output port encoding seen by the crossbar/arbiter.
  localparam logic [2:0] PORT_N     = 3'd0;
  localparam logic [2:0] PORT_S     = 3'd1;
  localparam logic [2:0] PORT_W     = 3'd2;
  localparam logic [2:0] PORT_E     = 3'd3;
  localparam logic [2:0] PORT_LOCAL = 3'd4;

  // Coordinates as 4-bit header-field values.
  localparam logic [3:0] ROW_C     = 4'(ROW);
  localparam logic [3:0] COLUMN_C  = 4'(COLUMN);
  localparam logic [3:0] ROWS_C    = 4'(ROWS);
  localparam logic [3:0] COLUMNS_C = 4'(COLUMNS);

  // ---------------------------------------------------------------------------
  // Header parse
  // ---------------------------------------------------------------------------
  logic [3:0] trgt_r;
  logic [3:0] trgt_c;
  logic       mode;
  logic       legal;

  assign trgt_r = in_data[PCK_SZ-9 -: 4];
  assign trgt_c = in_data[PCK_SZ-13 -: 4];
  assign mode   = in_data[PCK_SZ-17];

  assign legal = (trgt_r >= 4'd1) && (trgt_r <= ROWS_C) &&
                 (trgt_c >= 4'd1) && (trgt_c <= COLUMNS_C);

  // ---------------------------------------------------------------------------
  // Route selection
  // ---------------------------------------------------------------------------
  logic              row_move;
  logic              col_move;
  logic              use_row_axis;
  logic [2:0]        rt_port;
  logic [3:0]        nxt_r;
  logic [3:0]        nxt_c;
  logic [PCK_SZ-1:0] routed_data;

  assign row_move = (trgt_r != ROW_C);
  assign col_move = (trgt_c != COLUMN_C);
  // Row-first resolves the row axis whenever it still differs; column-first
  // only falls back to the row axis once the column already matches.
  assign use_row_axis = mode ? row_move : !col_move;

  // Pick the output port and the neighbour coordinates for the chosen axis.
  always_comb begin
    rt_port = PORT_LOCAL;
    nxt_r   = ROW_C;
    nxt_c   = COLUMN_C;
    if (!row_move && !col_move) begin
      rt_port = PORT_LOCAL;
    end else if (use_row_axis) begin
      if (trgt_r < ROW_C) begin
        rt_port = PORT_N;
        nxt_r   = ROW_C - 4'd1;
      end else begin
        rt_port = PORT_S;
        nxt_r   = ROW_C + 4'd1;
      end
    end else begin
      if (trgt_c < COLUMN_C) begin
        rt_port = PORT_W;
        nxt_c   = COLUMN_C - 4'd1;
      end else begin
        rt_port = PORT_E;
        nxt_c   = COLUMN_C + 4'd1;
      end
    end
  end

  // Only the next-jump byte changes; every other header/payload bit passes.
  assign routed_data = {nxt_r, nxt_c, in_data[PCK_SZ-9:0]};

  // ---------------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------------
  logic [1:0] count_q, count_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       accept;
  logic       push;
  logic       drop;
  logic       pop;

  assign accept = in_valid && in_ready_q;
  assign push   = accept && legal;
  assign drop   = accept && !legal;
  assign pop    = out_valid_q && out_ready;

  // ---------------------------------------------------------------------------
  // Two-entry FIFO: head drives the outputs directly, tail holds the second
  // packet. On pop with two entries the tail slides into the head.
  // ---------------------------------------------------------------------------
  logic [PCK_SZ-1:0] head_data_q, head_data_d;
  logic [2:0]        head_port_q, head_port_d;
  logic [PCK_SZ-1:0] tail_data_q, tail_data_d;
  logic [2:0]        tail_port_q, tail_port_d;

  // FIFO next-state: head/tail contents and occupancy.
  always_comb begin
    head_data_d = head_data_q;
    head_port_d = head_port_q;
    tail_data_d = tail_data_q;
    tail_port_d = tail_port_q;
    count_d     = count_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_data_d = routed_data;
          head_port_d = rt_port;
          count_d     = 2'd1;
        end else begin
          tail_data_d = routed_data;
          tail_port_d = rt_port;
          count_d     = 2'd2;
        end
      end
      2'b01: begin
        if (count_q == 2'd2) begin
          head_data_d = tail_data_q;
          head_port_d = tail_port_q;
          count_d     = 2'd1;
        end else begin
          // Head contents are left in place so the outputs keep their
          // last values while the FIFO is empty.
          count_d = 2'd0;
        end
      end
      2'b11: begin
        // Push is only possible with count 1 here (count 2 blocks input),
        // so the new packet replaces the departing head directly.
        head_data_d = routed_data;
        head_port_d = rt_port;
        count_d     = 2'd1;
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Flow-control flags are registered from the next occupancy so that
  // out_ready never reaches in_ready combinationally.
  always_comb begin
    in_ready_d  = (count_d != 2'd2);
    out_valid_d = (count_d != 2'd0);
  end

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  // Forwarded count wraps; error count sticks at all-ones.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (push) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
    if (drop && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State registers; reset discards everything held in the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_data_q <= '0;
      head_port_q <= '0;
      tail_data_q <= '0;
      tail_port_q <= '0;
      count_q     <= 2'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      pkt_cnt_q   <= 16'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      head_data_q <= head_data_d;
      head_port_q <= head_port_d;
      tail_data_q <= tail_data_d;
      tail_port_q <= tail_port_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_data_q;
  assign out_port  = head_port_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_hdr_route_stage.sv
// Directed bench for hdr_route_stage with the default parameters
// (router at row 2, column 2 of a 4x4 mesh).

module tb_hdr_route_stage;

  localparam int PCK_SZ = 40;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [PCK_SZ-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [PCK_SZ-1:0] out_data;
  logic [2:0]        out_port;
  logic              out_ready;
  logic [15:0]       pkt_cnt;
  logic [7:0]        err_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0]       exp_pkt;
  logic [PCK_SZ-1:0] last_data;
  logic [2:0]        last_port;

  hdr_route_stage #(
    .PCK_SZ(40), .ROW(2), .COLUMN(2), .ROWS(4), .COLUMNS(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_port (out_port),
    .out_ready(out_ready),
    .pkt_cnt  (pkt_cnt),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [PCK_SZ-1:0] make_pkt(input logic [7:0] jmp, input logic [3:0] r,
                                                 input logic [3:0] c, input logic m,
                                                 input logic [22:0] lo);
    return {jmp, r, c, m, lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) tick();
    n_cmp++; if (in_ready !== 1'b0) begin $display("FAIL rst_in_ready: got %b want 0", in_ready); n_fail++; end
    n_cmp++; if (out_valid !== 1'b0) begin $display("FAIL rst_out_valid: got %b want 0", out_valid); n_fail++; end
    n_cmp++; if (out_data !== 40'h0) begin $display("FAIL rst_out_data: got %h want 0", out_data); n_fail++; end
    n_cmp++; if (out_port !== 3'd0) begin $display("FAIL rst_out_port: got %0d want 0", out_port); n_fail++; end
    n_cmp++; if (pkt_cnt !== 16'd0) begin $display("FAIL rst_pkt_cnt: got %0d want 0", pkt_cnt); n_fail++; end
    n_cmp++; if (err_cnt !== 8'd0) begin $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); n_fail++; end
    reset = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin $display("FAIL rst_release_in_ready: got %b want 1", in_ready); n_fail++; end
    exp_pkt = 16'd0; last_data = '0; last_port = 3'd0;
    $display("reset: done");
  endtask

  // One legal packet through an empty FIFO with out_ready high.
  task automatic send_route(input string name, input logic [3:0] r, input logic [3:0] c,
                            input logic m, input logic [2:0] ep, input logic [7:0] ej);
    logic [PCK_SZ-1:0] pkt;
    logic [PCK_SZ-1:0] want;
    pkt  = make_pkt(8'hA5, r, c, m, 23'h2B3C5D ^ {19'd0, r});
    want = {ej, pkt[31:0]};
    in_data = pkt; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_pkt = exp_pkt + 16'd1;
    n_cmp++; if (out_valid !== 1'b1) begin $display("FAIL %s_valid: got %b want 1", name, out_valid); n_fail++; end
    n_cmp++; if (out_port !== ep) begin $display("FAIL %s_port: got %0d want %0d", name, out_port, ep); n_fail++; end
    n_cmp++; if (out_data !== want) begin $display("FAIL %s_data: got %h want %h", name, out_data, want); n_fail++; end
    n_cmp++; if (pkt_cnt !== exp_pkt) begin $display("FAIL %s_pkt_cnt: got %0d want %0d", name, pkt_cnt, exp_pkt); n_fail++; end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin $display("FAIL %s_drain: got %b want 0", name, out_valid); n_fail++; end
    n_cmp++; if (out_data !== want) begin $display("FAIL %s_hold: got %h want %h", name, out_data, want); n_fail++; end
    last_data = want; last_port = ep;
    $display("route %s: trgt=(%0d,%0d) mode=%0d port=%0d data=%h", name, r, c, m, out_port, out_data);
  endtask

  task automatic test_row_first();
    send_route("row_first_S", 4'd4, 4'd1, 1'b1, 3'd1, 8'h32);
    send_route("row_first_N", 4'd1, 4'd3, 1'b1, 3'd0, 8'h12);
  endtask

  task automatic test_col_first();
    send_route("col_first_W", 4'd4, 4'd1, 1'b0, 3'd2, 8'h21);
    send_route("col_first_E", 4'd1, 4'd3, 1'b0, 3'd3, 8'h23);
  endtask

  task automatic test_local();
    send_route("local_m0", 4'd2, 4'd2, 1'b0, 3'd4, 8'h22);
    send_route("local_m1", 4'd2, 4'd2, 1'b1, 3'd4, 8'h22);
  endtask

  task automatic test_boundary_legal();
    send_route("corner_44", 4'd4, 4'd4, 1'b0, 3'd3, 8'h23);
    send_route("corner_11", 4'd1, 4'd1, 1'b1, 3'd0, 8'h12);
  endtask

  task automatic test_illegal();
    logic [3:0] rs [4] = '{4'd7, 4'd2, 4'd0, 4'd5};
    logic [3:0] cs [4] = '{4'd1, 4'd0, 4'd3, 4'd2};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = make_pkt(8'h3C, rs[i], cs[i], 1'b1, 23'h000001);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (in_ready !== 1'b1) begin $display("FAIL illegal%0d_in_ready: got %b want 1", i, in_ready); n_fail++; end
      n_cmp++; if (out_valid !== 1'b0) begin $display("FAIL illegal%0d_out_valid: got %b want 0", i, out_valid); n_fail++; end
      n_cmp++; if (err_cnt !== 8'(i + 1)) begin $display("FAIL illegal%0d_err_cnt: got %0d want %0d", i, err_cnt, i + 1); n_fail++; end
      n_cmp++; if (pkt_cnt !== exp_pkt) begin $display("FAIL illegal%0d_pkt_cnt: got %0d want %0d", i, pkt_cnt, exp_pkt); n_fail++; end
      n_cmp++; if (out_data !== last_data) begin $display("FAIL illegal%0d_out_data: got %h want %h", i, out_data, last_data); n_fail++; end
      n_cmp++; if (out_port !== last_port) begin $display("FAIL illegal%0d_out_port: got %0d want %0d", i, out_port, last_port); n_fail++; end
      $display("illegal %0d: trgt=(%0d,%0d) err_cnt=%0d", i, rs[i], cs[i], err_cnt);
    end
  endtask

  // err_cnt is 4 on entry; 100 more gives 104, a further 200 saturates.
  task automatic test_err_saturate();
    in_data = make_pkt(8'h00, 4'd7, 4'd1, 1'b1, 23'h0);
    in_valid = 1'b1;
    repeat (100) tick();
    n_cmp++; if (err_cnt !== 8'd104) begin $display("FAIL sat_mid: got %0d want 104", err_cnt); n_fail++; end
    repeat (200) tick();
    in_valid = 1'b0;
    n_cmp++; if (err_cnt !== 8'hFF) begin $display("FAIL sat_end: got %0d want 255", err_cnt); n_fail++; end
    n_cmp++; if (pkt_cnt !== exp_pkt) begin $display("FAIL sat_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt); n_fail++; end
    $display("saturate: err_cnt=%0d", err_cnt);
  endtask

  task automatic test_back_to_back();
    logic [PCK_SZ-1:0] a, b, c, wa, wb, wc;
    a = make_pkt(8'h11, 4'd1, 4'd2, 1'b1, 23'h0AAAA1);  // N, next (1,2)
    b = make_pkt(8'h22, 4'd3, 4'd2, 1'b1, 23'h055552);  // S, next (3,2)
    c = make_pkt(8'h33, 4'd2, 4'd1, 1'b0, 23'h012343);  // W, next (2,1)
    wa = {8'h12, a[31:0]};
    wb = {8'h32, b[31:0]};
    wc = {8'h21, c[31:0]};
    out_ready = 1'b0;
    in_data = a; in_valid = 1'b1;
    tick();
    in_data = b;
    tick();
    in_data = c;
    n_cmp++; if (in_ready !== 1'b0) begin $display("FAIL bp_full_in_ready: got %b want 0", in_ready); n_fail++; end
    n_cmp++; if (out_data !== wa) begin $display("FAIL bp_head_a: got %h want %h", out_data, wa); n_fail++; end
    tick();
    n_cmp++; if (out_data !== wa) begin $display("FAIL bp_hold_a: got %h want %h", out_data, wa); n_fail++; end
    n_cmp++; if (out_port !== 3'd0) begin $display("FAIL bp_hold_port: got %0d want 0", out_port); n_fail++; end
    n_cmp++; if (in_ready !== 1'b0) begin $display("FAIL bp_still_full: got %b want 0", in_ready); n_fail++; end
    n_cmp++; if (pkt_cnt !== exp_pkt + 16'd2) begin $display("FAIL bp_pkt_cnt2: got %0d want %0d", pkt_cnt, exp_pkt + 16'd2); n_fail++; end
    $display("back_to_back: A,B held, out=%h", out_data);
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_data !== wb) begin $display("FAIL bp_head_b: got %h want %h", out_data, wb); n_fail++; end
    n_cmp++; if (out_port !== 3'd1) begin $display("FAIL bp_port_b: got %0d want 1", out_port); n_fail++; end
    n_cmp++; if (in_ready !== 1'b1) begin $display("FAIL bp_reopen: got %b want 1", in_ready); n_fail++; end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin $display("FAIL bp_valid_c: got %b want 1", out_valid); n_fail++; end
    n_cmp++; if (out_data !== wc) begin $display("FAIL bp_head_c: got %h want %h", out_data, wc); n_fail++; end
    n_cmp++; if (out_port !== 3'd2) begin $display("FAIL bp_port_c: got %0d want 2", out_port); n_fail++; end
    n_cmp++; if (pkt_cnt !== exp_pkt + 16'd3) begin $display("FAIL bp_pkt_cnt3: got %0d want %0d", pkt_cnt, exp_pkt + 16'd3); n_fail++; end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin $display("FAIL bp_empty: got %b want 0", out_valid); n_fail++; end
    n_cmp++; if (out_data !== wc) begin $display("FAIL bp_empty_hold: got %h want %h", out_data, wc); n_fail++; end
    exp_pkt = exp_pkt + 16'd3;
    $display("back_to_back: A,B,C drained, pkt_cnt=%0d", pkt_cnt);
  endtask

  task automatic test_reset_mid();
    logic [PCK_SZ-1:0] d, wd;
    out_ready = 1'b0;
    in_data = make_pkt(8'h44, 4'd1, 4'd2, 1'b1, 23'h7);
    in_valid = 1'b1;
    tick();
    in_data = make_pkt(8'h55, 4'd3, 4'd2, 1'b1, 23'h8);
    tick();
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin $display("FAIL rm_full: got %b want 0", in_ready); n_fail++; end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin $display("FAIL rm_out_valid: got %b want 0", out_valid); n_fail++; end
    n_cmp++; if (in_ready !== 1'b0) begin $display("FAIL rm_in_ready: got %b want 0", in_ready); n_fail++; end
    n_cmp++; if (pkt_cnt !== 16'd0) begin $display("FAIL rm_pkt_cnt: got %0d want 0", pkt_cnt); n_fail++; end
    n_cmp++; if (err_cnt !== 8'd0) begin $display("FAIL rm_err_cnt: got %0d want 0", err_cnt); n_fail++; end
    n_cmp++; if (out_data !== 40'h0) begin $display("FAIL rm_out_data: got %h want 0", out_data); n_fail++; end
    tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin $display("FAIL rm_release: got %b want 1", in_ready); n_fail++; end
    n_cmp++; if (out_valid !== 1'b0) begin $display("FAIL rm_empty: got %b want 0", out_valid); n_fail++; end
    d  = make_pkt(8'hEE, 4'd2, 4'd4, 1'b1, 23'h1F0F3);  // E, next (2,3)
    wd = {8'h23, d[31:0]};
    out_ready = 1'b1; in_data = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin $display("FAIL rm_d_valid: got %b want 1", out_valid); n_fail++; end
    n_cmp++; if (out_data !== wd) begin $display("FAIL rm_d_data: got %h want %h", out_data, wd); n_fail++; end
    n_cmp++; if (pkt_cnt !== 16'd1) begin $display("FAIL rm_d_pkt_cnt: got %0d want 1", pkt_cnt); n_fail++; end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin $display("FAIL rm_discarded: got %b want 0", out_valid); n_fail++; end
    $display("reset_mid: FIFO flushed, post-reset packet out=%h", wd);
  endtask

  initial begin
    test_reset();
    test_row_first();
    test_col_first();
    test_local();
    test_boundary_legal();
    test_illegal();
    test_err_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hdr_route_stage.md
Name: hdr_route_stage

Overview:
- Next-hop route-compute stage for one mesh router, directly downstream of the packet header map.
- Parses the target row, target column and mode from each incoming packet, selects the output port, and overwrites the next-jump field with the next router's coordinates.
- Forwards the packet through a 2-entry output FIFO using valid/ready handshakes.
- Sits between a router input buffer and the crossbar/arbiter.

Parameters:
- PCK_SZ, 40, packet width; field map follows the team header map.
- ROW, 2, this router's row coordinate (1..ROWS).
- COLUMN, 2, this router's column coordinate (1..COLUMNS).
- ROWS, 4, mesh row count (max 15).
- COLUMNS, 4, mesh column count (max 15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- in_valid  in  1  upstream packet valid.
- in_data  in  PCK_SZ  upstream packet.
- in_ready  out  1  stage can accept a packet (FIFO count < 2).
- out_valid  out  1  FIFO head valid.
- out_data  out  PCK_SZ  FIFO head packet with NXT_JUMP rewritten.
- out_port  out  3  FIFO head port: 0=N, 1=S, 2=W, 3=E, 4=LOCAL.
- out_ready  in  1  downstream accepts head.
- pkt_cnt  out  16  forwarded-packet counter, wraps.
- err_cnt  out  8  dropped-packet counter, saturates at 8'hFF.

Behaviour:
- Clock and reset
  - One clock: clk.
  - reset is asynchronous, active-high.
  - While reset is high: FIFO count=0, in_ready=0, out_valid=0, out_data=0, out_port=0, pkt_cnt=0, err_cnt=0.
  - in_ready rises in the first cycle after reset deasserts.
  - Reset mid-transfer discards all stored packets; no partial outputs.
- Field extraction
  - trgt_r = in_data[PCK_SZ-9:PCK_SZ-12] (4 bits).
  - trgt_c = in_data[PCK_SZ-13:PCK_SZ-16] (4 bits).
  - mode = in_data[PCK_SZ-17].
- Legality
  - A packet is legal when 1 <= trgt_r <= ROWS and 1 <= trgt_c <= COLUMNS.
- Route, combinational on in_data
  - trgt == (ROW,COLUMN): port LOCAL; next = (ROW,COLUMN).
  - mode=1 (row-first):
    - trgt_r != ROW: move along the row axis. trgt_r<ROW gives N with next (ROW-1,COLUMN); trgt_r>ROW gives S with next (ROW+1,COLUMN).
    - Otherwise move along the column axis. trgt_c<COLUMN gives W with next (ROW,COLUMN-1); trgt_c>COLUMN gives E with next (ROW,COLUMN+1).
  - mode=0 (column-first): resolve the column axis first, then the row axis, with the same rules.
- Rewrite
  - out packet = in_data with bits [PCK_SZ-1:PCK_SZ-8] = {next_row[3:0], next_col[3:0]}.
  - All other bits pass unchanged, including ID, DST, SRC, mode, targets and bits [1:0].
- Accept
  - A transfer occurs when in_valid && in_ready at a rising edge.
  - Legal packet: pushed into the FIFO; pkt_cnt++.
  - Illegal packet: consumed (handshake completes) but not pushed; err_cnt++ with saturation; out_* unaffected.
- Latency
  - A legal packet accepted at edge k into an empty FIFO drives out_valid=1 with its data in the cycle after edge k (1-cycle latency).
- FIFO
  - 2 entries, in-order, registered outputs.
  - Pop when out_valid && out_ready.
  - in_ready = (count < 2), derived from registered count only; no combinational path from out_ready to in_ready.
  - Simultaneous push and pop with count=1: count stays 1; the new packet becomes head after the old head leaves.
  - count=2: in_ready=0; upstream holds in_data stable.
  - count=0 with out_ready=1: no pop; out_valid=0.
- Output hold
  - out_data and out_port hold stable while out_valid && !out_ready.
  - When out_valid=0, out_data and out_port keep their last values.
- Counters
  - pkt_cnt wraps at 16'hFFFF→0.
  - err_cnt holds at 8'hFF.

Test Plan:
- Reset default params; drive 0x00_4_1_1_000000 pattern (trgt_r=4, trgt_c=1, mode=1), out_ready=1 -> next cycle out_valid=1, out_port=1 (S), out_data[39:32]=8'h32, other bits equal input, pkt_cnt=1.
- Same packet with mode=0 -> out_port=2 (W), out_data[39:32]=8'h21.
- trgt=(2,2), either mode -> out_port=4 (LOCAL), out_data[39:32]=8'h22.
- trgt_r=7, trgt_c=1 -> in_ready stays 1, out_valid stays 0, err_cnt=1, pkt_cnt unchanged. Send 300 illegal packets -> err_cnt=8'hFF.
- Backpressure: out_ready=0, three legal packets A,B,C offered back-to-back -> A,B accepted, in_ready=0 with C held, out_data=A stable. Raise out_ready -> outputs A,B,C in order on consecutive cycles, with C accepted the cycle after A pops.
- Assert reset while count=2 -> out_valid=0, in_ready=0, counters=0 immediately (asynchronous). After release, the FIFO is empty and the next legal packet emerges with 1-cycle latency.
